// File: rtl/mac_accum_if.sv
// Handshake bundle between the MAC stream source, the accumulator and the
// result consumer. The accumulator side uses the slave modport.
interface mac_accum_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 32
);
    // beat stream from the MAC
    logic                  in_valid;
    logic                  in_ready;
    logic [ACC_WIDTH-1:0]  in_data;
    logic                  in_last;
    logic [DATA_WIDTH-1:0] bias;
    // result stream to the consumer
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_sat;
    logic                  out_err;

    modport master (
        output in_valid, in_data, in_last, bias, out_ready,
        input  in_ready, out_valid, out_data, out_sat, out_err
    );

    modport slave (
        input  in_valid, in_data, in_last, bias, out_ready,
        output in_ready, out_valid, out_data, out_sat, out_err
    );
endinterface

// File: rtl/mac_accum.sv
// Saturating vector accumulator behind the 4-lane MAC. It sums a
// variable-length stream of Q2.14 partial sums and adds a per-vector bias.
// One clipped DATA_WIDTH result per vector is presented over valid/ready.
// The beat that consumes a held result may open the next vector, so
// back-to-back vectors run without a bubble.
module mac_accum #(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 32,
    parameter int MAX_BEATS  = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    mac_accum_if.slave  io
);
    localparam int CNT_W = $clog2(MAX_BEATS + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BEATS);

    localparam logic [ACC_WIDTH-1:0]  ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0]  ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    localparam logic [DATA_WIDTH-1:0] OUT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] OUT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [ACC_WIDTH-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]      beat_cnt_q, beat_cnt_d;
    logic                  sat_flag_q, sat_flag_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_sat_q, out_sat_d;
    logic                  out_err_q, out_err_d;

    // datapath intermediates
    logic                  in_ready;
    logic                  accept;
    logic                  first_beat;
    logic [ACC_WIDTH-1:0]  acc_base;
    logic [ACC_WIDTH:0]    acc_sum;
    logic                  acc_clip;
    logic [ACC_WIDTH-1:0]  acc_new;
    logic [CNT_W-1:0]      cnt_new;
    logic                  sat_new;
    logic                  terminal;
    logic                  out_clip;
    logic [DATA_WIDTH-1:0] out_new;
    logic [ACC_WIDTH-DATA_WIDTH:0] acc_top;

    // Saturating add of the incoming beat onto either the bias (new vector)
    // or the running accumulator, plus the narrowing clip to DATA_WIDTH.
    always_comb begin
        // The only stall is a held result the consumer is not taking.
        in_ready   = !(state_q == HOLD && !io.out_ready);
        accept     = io.in_valid && in_ready;
        // Outside ACCUM there is no open vector, so a beat starts one.
        first_beat = (state_q != ACCUM);

        acc_base = first_beat
                 ? {{(ACC_WIDTH-DATA_WIDTH){io.bias[DATA_WIDTH-1]}}, io.bias}
                 : acc_q;
        // One guard bit: overflow shows up as the two top bits disagreeing.
        acc_sum  = {acc_base[ACC_WIDTH-1], acc_base}
                 + {io.in_data[ACC_WIDTH-1], io.in_data};
        acc_clip = acc_sum[ACC_WIDTH] ^ acc_sum[ACC_WIDTH-1];
        if (acc_clip)
            acc_new = acc_sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
        else
            acc_new = acc_sum[ACC_WIDTH-1:0];

        cnt_new  = (first_beat ? '0 : beat_cnt_q) + 1'b1;
        sat_new  = (first_beat ? 1'b0 : sat_flag_q) | acc_clip;
        terminal = io.in_last || (cnt_new == MAX_CNT);

        // Value fits DATA_WIDTH only if every bit above the output sign bit
        // replicates it.
        acc_top  = acc_new[ACC_WIDTH-1:DATA_WIDTH-1];
        out_clip = !((&acc_top) || !(|acc_top));
        if (out_clip)
            out_new = acc_new[ACC_WIDTH-1] ? OUT_MIN : OUT_MAX;
        else
            out_new = acc_new[DATA_WIDTH-1:0];
    end

    // Next-state logic: beats advance the vector, a terminal beat loads the
    // result registers, a consumed result with no new beat returns to IDLE.
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        beat_cnt_d = beat_cnt_q;
        sat_flag_d = sat_flag_q;
        out_data_d = out_data_q;
        out_sat_d  = out_sat_q;
        out_err_d  = out_err_q;

        if (accept) begin
            acc_d      = acc_new;
            beat_cnt_d = cnt_new;
            sat_flag_d = sat_new;
            if (terminal) begin
                state_d    = HOLD;
                out_data_d = out_new;
                out_sat_d  = sat_new | out_clip;
                out_err_d  = !io.in_last;
            end else begin
                state_d    = ACCUM;
            end
        end else if (state_q == HOLD && io.out_ready) begin
            state_d = IDLE;
        end
    end

    // State and result registers; reset discards any partial vector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            beat_cnt_q <= '0;
            sat_flag_q <= 1'b0;
            out_data_q <= '0;
            out_sat_q  <= 1'b0;
            out_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            beat_cnt_q <= beat_cnt_d;
            sat_flag_q <= sat_flag_d;
            out_data_q <= out_data_d;
            out_sat_q  <= out_sat_d;
            out_err_q  <= out_err_d;
        end
    end

    // A result is on offer exactly while the FSM sits in HOLD.
    always_comb begin
        io.in_ready  = in_ready;
        io.out_valid = (state_q == HOLD);
        io.out_data  = out_data_q;
        io.out_sat   = out_sat_q;
        io.out_err   = out_err_q;
    end
endmodule

// File: doc/mac_accum.md
# mac_accum

Sequential accumulation stage that sits directly downstream of the 4-lane MAC. It takes a stream of signed Q-format partial sums (one MAC result per beat) and accumulates them over a variable-length vector with saturating arithmetic. It adds a per-vector bias and emits one saturated DATA_WIDTH result per vector over a valid/ready handshake. Together with the MAC it forms the dot-product engine for LSTM gate pre-activations.

## Interface
- DATA_WIDTH, 16: width of bias and output; Q2.14 fixed point.
- ACC_WIDTH, 32: accumulator and input width; equals 2*DATA_WIDTH, the MAC result width.
- MAX_BEATS, 16: maximum beats per vector; counter width is clog2(MAX_BEATS+1).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  beat valid.
- in_ready  out  1  beat accepted when in_valid && in_ready.
- in_data  in  ACC_WIDTH  signed partial sum from the MAC, already aligned to Q2.14.
- in_last  in  1  marks the final beat of a vector.
- bias  in  DATA_WIDTH  signed Q2.14 bias; sampled only on the first beat of a vector.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  DATA_WIDTH  signed saturated result.
- out_sat  out  1  result was clipped (accumulator or output saturation).
- out_err  out  1  vector was force-terminated at MAX_BEATS without in_last.

## Operation
- States: IDLE (no vector open), ACCUM (vector open), HOLD (result presented).
- in_ready = !(state==HOLD && !out_ready). It is 1 in IDLE and ACCUM. In HOLD it is 1 only in the cycle the result is consumed.
- Accepted beat in IDLE, or in HOLD while out_ready is high (first beat of a vector):
  - acc = sat_acc(sext(bias) + in_data); beat_cnt = 1; sat_flag = accumulator clip of this add.
- Accepted beat in ACCUM: acc = sat_acc(acc + in_data); beat_cnt += 1; sat_flag |= clip.
- sat_acc: compute at ACC_WIDTH+1 bits. Clamp to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1].
- A beat is terminal if in_last=1 or beat_cnt reaches MAX_BEATS with this beat.
  - Terminal beat: go to HOLD. Register out_data = sat_out(new acc) clamped to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
  - Set out_sat = sat_flag | output clip.
  - Set out_err = (in_last==0).
- Non-terminal beat: go to ACCUM (or stay in ACCUM).
- HOLD: out_valid=1, and out_data, out_sat and out_err stay stable until out_ready.
  - On out_ready without an accepted beat: go to IDLE.
  - On out_ready with an accepted beat: that beat opens the next vector in the same cycle.
- A single-beat vector (first beat with in_last=1) goes directly to HOLD.
- in_valid=0 in ACCUM: hold state; no timeout.

## Timing
- Reset (asynchronous, while rst_n=0): state=IDLE, acc=0, beat_cnt=0, out_valid=0, out_data=0, out_sat=0, out_err=0. in_ready=1.
- Latency: terminal beat accepted at edge t gives out_valid=1 after edge t, i.e. 1 cycle.
- Throughput: one beat per cycle sustained. Back-to-back vectors have no bubble when out_ready is high in HOLD.
- out_valid falls on the edge after the out_ready handshake, unless a terminal single-beat vector was accepted in that same cycle. In that case out_valid stays 1 with new data.
- Reset mid-vector discards the partial accumulation. No output is produced for the aborted vector.
- in_data and bias are don't-care when in_valid=0 or in_ready=0.

## Test plan
- Basic accumulation: bias=0, beats 16384, 8192, -8192(last) -> one cycle after the last beat, out_valid=1, out_data=16384, out_sat=0, out_err=0.
- Output saturation: bias=16384, beats 30000, 10000(last) -> out_data=32767, out_sat=1. Separately, bias=0, beat -40000(last) -> out_data=-32768, out_sat=1.
- Accumulator saturation: beats 0x7FFF0000, 0x7FFF0000, -0x10000000(last), bias=0 -> acc clamps at 0x7FFFFFFF, then lands at 0x6FFFFFFF -> out_data=32767, out_sat=1.
- Backpressure and chaining: hold out_ready=0 for 3 cycles after a result -> in_ready=0, outputs stable. Then raise out_ready with in_valid=1, beat 50(last), bias=0 -> handshake completes, next cycle out_data=50 with out_valid continuously 1.
- MAX_BEATS termination: MAX_BEATS=4, bias=10, four beats of 100 with in_last=0 -> out_data=410, out_err=1. The next beat 7(last) with bias=0 gives out_data=7, out_err=0.
- Reset mid-vector: after 2 accepted beats of 1000, pulse rst_n low mid-cycle -> out_valid=0 immediately. After release, beat 50(last) with bias=0 -> out_data=50.
